// File: rtl/kirby_gfx_pkg.sv
// Shared types and defaults for the layer fetch scheduler.
//   sprite_cfg_t  : sprite placement, animation frame and visibility
//                   (plus a mirror flag when SPRITE_HFLIP_EN is defined)
//   fetch_state_e : background slot / sprite slot of the ROM port
//   DEF_*         : default sprite box size and transparent palette index
//   wrap_sub      : 10-bit screen-coordinate subtraction with wrap-around
package kirby_gfx_pkg;

  localparam int COORD_W     = 10;
  // Frame index storage width; the top zero-extends its FRAME_W-bit input
  // into this field, so FRAME_W must not exceed it.
  localparam int MAX_FRAME_W = 8;

  localparam int         DEF_SP_W       = 32;
  localparam int         DEF_SP_H       = 32;
  localparam logic [3:0] DEF_TRANSP_IDX = 4'd2;

  typedef enum logic {
    S_BG = 1'b0,
    S_SP = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [COORD_W-1:0]     x;
    logic [COORD_W-1:0]     y;
    logic [MAX_FRAME_W-1:0] frame;
    logic                   show;
`ifdef SPRITE_HFLIP_EN
    logic                   hflip;
`endif
  } sprite_cfg_t;

  // Unsigned wrap is intentional: a pixel left of / above the sprite gives
  // a huge offset, which the box compare then rejects.
  function automatic logic [COORD_W-1:0] wrap_sub(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
    return a - b;
  endfunction

endpackage

// File: rtl/layer_fetch_scheduler_if.sv
// Bus bundle of the layer fetch scheduler.
//   pixel strobe (pix_en, DrawX, DrawY), frame_start, sprite config
//   valid/ready channel (cfg_*), graphics ROM port (mem_rd, mem_addr,
//   mem_data) and composited output (idx_out, layer_sel, out_valid, overrun).
//   cfg_hflip exists only when SPRITE_HFLIP_EN is defined.
// Modports: slave = the scheduler, master = the video/ROM environment.
interface layer_fetch_scheduler_if
  import kirby_gfx_pkg::*;
#(
  parameter int ADDR_W  = 18,
  parameter int FRAME_W = 3
);

  logic               pix_en;
  logic [COORD_W-1:0] DrawX;
  logic [COORD_W-1:0] DrawY;
  logic               frame_start;

  logic               cfg_valid;
  logic               cfg_ready;
  logic [COORD_W-1:0] cfg_x;
  logic [COORD_W-1:0] cfg_y;
  logic [FRAME_W-1:0] cfg_frame;
  logic               cfg_show;
`ifdef SPRITE_HFLIP_EN
  logic               cfg_hflip;
`endif

  logic               mem_rd;
  logic [ADDR_W-1:0]  mem_addr;
  logic [3:0]         mem_data;

  logic [3:0]         idx_out;
  logic               layer_sel;
  logic               out_valid;
  logic               overrun;

  modport slave (
    input  pix_en, DrawX, DrawY, frame_start,
    input  cfg_valid, cfg_x, cfg_y, cfg_frame, cfg_show,
`ifdef SPRITE_HFLIP_EN
    input  cfg_hflip,
`endif
    input  mem_data,
    output cfg_ready, mem_rd, mem_addr,
    output idx_out, layer_sel, out_valid, overrun
  );

  modport master (
    output pix_en, DrawX, DrawY, frame_start,
    output cfg_valid, cfg_x, cfg_y, cfg_frame, cfg_show,
`ifdef SPRITE_HFLIP_EN
    output cfg_hflip,
`endif
    output mem_data,
    input  cfg_ready, mem_rd, mem_addr,
    input  idx_out, layer_sel, out_valid, overrun
  );

endinterface

// File: rtl/sprite_hit_calc.sv
// Combinational sprite box test and sprite ROM address generation.
//   cfg  : active sprite configuration
//   x, y : screen pixel being fetched
//   hit  : pixel lies inside the visible sprite box
//   addr : SP_BASE + frame*SP_W*SP_H + dy*SP_W + column
// With SPRITE_HFLIP_EN defined, cfg.hflip mirrors the column (SP_W-1-dx).
module sprite_hit_calc
  import kirby_gfx_pkg::*;
#(
  parameter int ADDR_W  = 18,
  parameter int SP_BASE = 76800,
  parameter int SP_W    = DEF_SP_W,
  parameter int SP_H    = DEF_SP_H
) (
  input  sprite_cfg_t        cfg,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic               hit,
  output logic [ADDR_W-1:0]  addr
);

  localparam logic [COORD_W-1:0] SP_W_C    = COORD_W'(SP_W);
  localparam logic [COORD_W-1:0] SP_H_C    = COORD_W'(SP_H);
  localparam logic [COORD_W-1:0] SP_W_LAST = COORD_W'(SP_W - 1);

  logic [COORD_W-1:0] dx;
  logic [COORD_W-1:0] dy;
  logic [COORD_W-1:0] col;

  always_comb begin
    dx = wrap_sub(x, cfg.x);
    dy = wrap_sub(y, cfg.y);
`ifdef SPRITE_HFLIP_EN
    col = cfg.hflip ? (SP_W_LAST - dx) : dx;
`else
    col = dx;
`endif
    hit  = cfg.show && (dx < SP_W_C) && (dy < SP_H_C);
    addr = ADDR_W'(SP_BASE)
         + ADDR_W'(cfg.frame) * ADDR_W'(SP_W * SP_H)
         + ADDR_W'(dy) * ADDR_W'(SP_W)
         + ADDR_W'(col);
  end

endmodule

// File: rtl/layer_fetch_scheduler.sv
// Shares one graphics ROM port between background and sprite fetches.
// Each pixel uses two ROM slots (background, then sprite if the pixel is in
// the sprite box), composites the sprite over the background with a
// transparent index and emits one palette index per pixel, 3 Clk after pix_en.
// Ports: Clk, Reset_n (async, active low), bus (slave modport): pixel strobe,
//   frame_start, sprite cfg valid/ready, ROM port, composited output, overrun.
// Optional: SPRITE_HFLIP_EN adds cfg_hflip (horizontal sprite mirror).
module layer_fetch_scheduler
  import kirby_gfx_pkg::*;
#(
  parameter int         ADDR_W     = 18,
  parameter int         BG_BASE    = 0,
  parameter int         BG_W       = 320,
  parameter int         BG_SHIFT   = 1,
  parameter int         SP_BASE    = 76800,
  parameter int         SP_W       = DEF_SP_W,
  parameter int         SP_H       = DEF_SP_H,
  parameter int         FRAME_W    = 3,
  parameter logic [3:0] TRANSP_IDX = DEF_TRANSP_IDX
) (
  input logic                  Clk,
  input logic                  Reset_n,
  layer_fetch_scheduler_if.slave bus
);

  fetch_state_e       state_reg, state_next;

  sprite_cfg_t        active_reg, shadow_reg, cfg_in;
  logic               pending_reg;
  logic               cfg_accept;

  logic [COORD_W-1:0] x_reg, y_reg;
  logic               hit_reg;
  logic               bg_cap_reg;
  logic               compose_reg;
  logic [3:0]         bg_idx_reg;

  logic               mem_rd_reg, mem_rd_next;
  logic [ADDR_W-1:0]  mem_addr_reg, mem_addr_next;
  logic [ADDR_W-1:0]  bg_addr;
  logic               sp_hit;
  logic [ADDR_W-1:0]  sp_addr;

  logic [3:0]         idx_reg;
  logic               layer_reg;
  logic               out_valid_reg;
  logic               overrun_reg;

  // ---------------- sprite configuration (shadow -> active) ----------------
  assign cfg_accept = bus.cfg_valid && !pending_reg;

  always_comb begin
    cfg_in       = '0;
    cfg_in.x     = bus.cfg_x;
    cfg_in.y     = bus.cfg_y;
    cfg_in.frame = MAX_FRAME_W'(bus.cfg_frame[FRAME_W-1:0]);
    cfg_in.show  = bus.cfg_show;
`ifdef SPRITE_HFLIP_EN
    cfg_in.hflip = bus.cfg_hflip;
`endif
  end

  // The active copy only moves on frame_start so a frame never tears.
  // A request arriving together with frame_start with nothing pending goes
  // straight to active instead of waiting a whole frame.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      active_reg  <= '0;
      shadow_reg  <= '0;
      pending_reg <= 1'b0;
    end else if (bus.frame_start) begin
      if (cfg_accept) begin
        active_reg <= cfg_in;
        shadow_reg <= cfg_in;
      end else if (pending_reg) begin
        active_reg <= shadow_reg;
      end
      pending_reg <= 1'b0;
    end else if (cfg_accept) begin
      shadow_reg  <= cfg_in;
      pending_reg <= 1'b1;
    end
  end

  // ---------------- address generation ----------------
  assign bg_addr = ADDR_W'(BG_BASE)
                 + ADDR_W'(bus.DrawY >> BG_SHIFT) * ADDR_W'(BG_W)
                 + ADDR_W'(bus.DrawX >> BG_SHIFT);

  sprite_hit_calc #(
    .ADDR_W  (ADDR_W),
    .SP_BASE (SP_BASE),
    .SP_W    (SP_W),
    .SP_H    (SP_H)
  ) u_hit (
    .cfg  (active_reg),
    .x    (x_reg),
    .y    (y_reg),
    .hit  (sp_hit),
    .addr (sp_addr)
  );

  // ---------------- slot FSM ----------------
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_reg <= S_BG;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_BG:    if (bus.pix_en) state_next = S_SP;
      S_SP:    state_next = S_BG;
      default: state_next = S_BG;
    endcase
  end

  // A pix_en landing in the sprite slot gets no fetch at all.
  always_comb begin
    mem_rd_next   = 1'b0;
    mem_addr_next = mem_addr_reg;
    case (state_reg)
      S_BG: if (bus.pix_en) begin
        mem_rd_next   = 1'b1;
        mem_addr_next = bg_addr;
      end
      S_SP: if (sp_hit) begin
        mem_rd_next   = 1'b1;
        mem_addr_next = sp_addr;
      end
      default: ;
    endcase
  end

  // ---------------- pipeline and compose ----------------
  // Background data returns the cycle after the sprite slot (bg_cap_reg);
  // sprite data returns one cycle later, where compose_reg selects the layer.
  // hit_reg still belongs to the composing pixel because the next pixel's
  // sprite slot updates it on the same edge the compose reads it.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      x_reg         <= '0;
      y_reg         <= '0;
      hit_reg       <= 1'b0;
      bg_cap_reg    <= 1'b0;
      compose_reg   <= 1'b0;
      bg_idx_reg    <= '0;
      mem_rd_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      idx_reg       <= '0;
      layer_reg     <= 1'b0;
      out_valid_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      mem_rd_reg   <= mem_rd_next;
      mem_addr_reg <= mem_addr_next;
      if (state_reg == S_BG && bus.pix_en) begin
        x_reg <= bus.DrawX;
        y_reg <= bus.DrawY;
      end
      if (state_reg == S_SP) begin
        hit_reg <= sp_hit;
        if (bus.pix_en) overrun_reg <= 1'b1;
      end
      bg_cap_reg  <= (state_reg == S_SP);
      compose_reg <= bg_cap_reg;
      if (bg_cap_reg) bg_idx_reg <= bus.mem_data;
      out_valid_reg <= compose_reg;
      if (compose_reg) begin
        if (hit_reg && bus.mem_data != TRANSP_IDX) begin
          idx_reg   <= bus.mem_data;
          layer_reg <= 1'b1;
        end else begin
          idx_reg   <= bg_idx_reg;
          layer_reg <= 1'b0;
        end
      end
    end
  end

  assign bus.cfg_ready = !pending_reg;
  assign bus.mem_rd    = mem_rd_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.idx_out   = idx_reg;
  assign bus.layer_sel = layer_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.overrun   = overrun_reg;

endmodule

// File: tb/tb_layer_fetch_scheduler.sv
// Bench for layer_fetch_scheduler: directed cases followed by random
// pixel/config/frame_start traffic, checked against a transaction-level
// reference model (expected ROM reads and composited pixels with due cycle).
module tb_layer_fetch_scheduler;

  localparam int ADDR_W    = 18;
  localparam int ROM_DEPTH = 1 << ADDR_W;

  logic Clk     = 1'b0;
  logic Reset_n = 1'b0;
  always #10 Clk = ~Clk;

  layer_fetch_scheduler_if #(.ADDR_W(ADDR_W), .FRAME_W(3)) bus ();

  layer_fetch_scheduler #(
    .ADDR_W(ADDR_W), .BG_BASE(0), .BG_W(320), .BG_SHIFT(1), .SP_BASE(76800),
    .SP_W(32), .SP_H(32), .FRAME_W(3), .TRANSP_IDX(4'd2)
  ) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  // ROM: palette index valid one Clk after mem_rd
  logic [3:0] rom [ROM_DEPTH];
  logic [3:0] rom_q = 4'd0;
  always @(posedge Clk) if (bus.mem_rd) rom_q <= rom[bus.mem_addr];
  assign bus.mem_data = rom_q;

  // ---------------- reference model ----------------
  typedef struct {
    bit [9:0] x;
    bit [9:0] y;
    bit [2:0] frame;
    bit       show;
    bit       hflip;
  } mcfg_t;
  typedef struct { int due; int addr; } rd_t;
  typedef struct { int due; bit [3:0] idx; bit layer; } out_t;

  mcfg_t m_active, m_shadow;
  bit    m_pending, m_busy, m_overrun;
  rd_t   rd_q[$];
  out_t  out_q[$];
  int    cyc;
  int    vectors;
  int    miscompares;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic mcfg_t mk(input int x, input int y, input int frame, input bit show);
    mcfg_t c;
    c.x = 10'(x); c.y = 10'(y); c.frame = 3'(frame); c.show = show; c.hflip = 1'b0;
    return c;
  endfunction

  // One accepted pixel, computed from the screen/sprite geometry directly.
  task automatic model_pixel(input bit [9:0] x, input bit [9:0] y);
    int bga, spa, col;
    bit [9:0] dx, dy;
    bit hit;
    out_t o;
    bga = (int'(y) >> 1) * 320 + (int'(x) >> 1);
    dx  = x - m_active.x;
    dy  = y - m_active.y;
    hit = m_active.show && (dx < 10'd32) && (dy < 10'd32);
    col = m_active.hflip ? (31 - int'(dx)) : int'(dx);
    spa = 76800 + int'(m_active.frame) * 1024 + int'(dy) * 32 + col;
    rd_q.push_back('{due: cyc, addr: bga});
    if (hit) rd_q.push_back('{due: cyc + 1, addr: spa});
    o.due = cyc + 3;
    if (hit && rom[spa] != 4'd2) begin o.idx = rom[spa]; o.layer = 1'b1; end
    else begin o.idx = rom[bga]; o.layer = 1'b0; end
    out_q.push_back(o);
  endtask

  task automatic model_edge();
    mcfg_t nc;
    bit acc;
    nc = mk(bus.cfg_x, bus.cfg_y, bus.cfg_frame, bus.cfg_show);
`ifdef SPRITE_HFLIP_EN
    nc.hflip = bus.cfg_hflip;
`endif
    acc = bus.cfg_valid && !m_pending;
    if (bus.frame_start) begin
      if (acc) m_active = nc;
      else if (m_pending) m_active = m_shadow;
      m_pending = 1'b0;
    end else if (acc) begin
      m_shadow  = nc;
      m_pending = 1'b1;
    end
    if (bus.pix_en && m_busy) begin
      m_overrun = 1'b1;
      m_busy    = 1'b0;
    end else if (bus.pix_en) begin
      model_pixel(bus.DrawX, bus.DrawY);
      m_busy = 1'b1;
    end else begin
      m_busy = 1'b0;
    end
  endtask

  task automatic monitor();
    check_eq("cfg_ready", bus.cfg_ready, !m_pending);
    check_eq("overrun", bus.overrun, m_overrun);
    if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
      check_eq("mem_rd", bus.mem_rd, 1'b1);
      check_eq("mem_addr", bus.mem_addr, rd_q[0].addr);
      void'(rd_q.pop_front());
    end else begin
      check_eq("mem_rd_idle", bus.mem_rd, 1'b0);
    end
    if (out_q.size() > 0 && out_q[0].due == cyc) begin
      check_eq("out_valid", bus.out_valid, 1'b1);
      check_eq("idx_out", bus.idx_out, out_q[0].idx);
      check_eq("layer_sel", bus.layer_sel, out_q[0].layer);
      void'(out_q.pop_front());
    end else begin
      check_eq("out_valid_idle", bus.out_valid, 1'b0);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    cyc++;
    if (Reset_n) model_edge();
    #1;
    monitor();
  endtask

  task automatic drive(input bit pix, input int x, input int y,
                       input bit cv, input mcfg_t c, input bit fs);
    bus.pix_en      = pix;
    bus.DrawX       = 10'(x);
    bus.DrawY       = 10'(y);
    bus.cfg_valid   = cv;
    bus.cfg_x       = c.x;
    bus.cfg_y       = c.y;
    bus.cfg_frame   = c.frame;
    bus.cfg_show    = c.show;
`ifdef SPRITE_HFLIP_EN
    bus.cfg_hflip   = c.hflip;
`endif
    bus.frame_start = fs;
    step();
    bus.pix_en      = 1'b0;
    bus.cfg_valid   = 1'b0;
    bus.frame_start = 1'b0;
  endtask

  mcfg_t nocfg;

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 0, 0, 1'b0, nocfg, 1'b0);
  endtask

  task automatic pixel(input int x, input int y);
    drive(1'b1, x, y, 1'b0, nocfg, 1'b0);
  endtask

  task automatic send_cfg(input mcfg_t c, input bit fs);
    drive(1'b0, 0, 0, 1'b1, c, fs);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_mem_rd"}, bus.mem_rd, 1'b0);
    check_eq({tag, "_mem_addr"}, bus.mem_addr, 0);
    check_eq({tag, "_idx_out"}, bus.idx_out, 4'd0);
    check_eq({tag, "_layer_sel"}, bus.layer_sel, 1'b0);
    check_eq({tag, "_out_valid"}, bus.out_valid, 1'b0);
    check_eq({tag, "_overrun"}, bus.overrun, 1'b0);
    check_eq({tag, "_cfg_ready"}, bus.cfg_ready, 1'b1);
  endtask

  // Reset asserted while a pixel is in flight: the pixel is dropped.
  task automatic async_reset();
    pixel(64, 64);
    #2 Reset_n = 1'b0;
    #1 check_reset_outputs("midrst");
    out_q.delete();
    rd_q.delete();
    m_active  = mk(0, 0, 0, 1'b0);
    m_shadow  = mk(0, 0, 0, 1'b0);
    m_pending = 1'b0;
    m_busy    = 1'b0;
    m_overrun = 1'b0;
    idle(3);
    Reset_n = 1'b1;
    idle(4);
  endtask

  bit    r_pix, r_cv, r_fs;
  int    r_x, r_y;
  mcfg_t r_c;

  initial begin
    vectors = 0; miscompares = 0; cyc = 0;
    nocfg = mk(0, 0, 0, 1'b0);
    m_active = nocfg; m_shadow = nocfg;
    m_pending = 1'b0; m_busy = 1'b0; m_overrun = 1'b0;
    bus.pix_en = 1'b0; bus.DrawX = '0; bus.DrawY = '0; bus.frame_start = 1'b0;
    bus.cfg_valid = 1'b0; bus.cfg_x = '0; bus.cfg_y = '0; bus.cfg_frame = '0;
    bus.cfg_show = 1'b0;
`ifdef SPRITE_HFLIP_EN
    bus.cfg_hflip = 1'b0;
`endif
    for (int i = 0; i < ROM_DEPTH; i++)
      rom[i] = (i >= 76800 && $urandom_range(0, 3) == 0) ? 4'd2 : 4'($urandom);

    // reset state
    idle(2);
    check_reset_outputs("reset");
    Reset_n = 1'b1;
    idle(2);

    // 1: background only
    rom[3205] = 4'd13;
    pixel(10, 20);
    check_eq("t1_bg_rd", bus.mem_rd, 1'b1);
    check_eq("t1_bg_addr", bus.mem_addr, 3205);
    idle(1);
    check_eq("t1_no_sp_rd", bus.mem_rd, 1'b0);
    idle(2);
    check_eq("t1_valid", bus.out_valid, 1'b1);
    check_eq("t1_idx", bus.idx_out, 4'd13);
    check_eq("t1_layer", bus.layer_sel, 1'b0);
    idle(1);

    // 2: opaque sprite pixel
    rom[8050] = 4'd9;
    rom[77824] = 4'd7;
    send_cfg(mk(100, 50, 1, 1'b1), 1'b0);
    check_eq("t2_ready_pending", bus.cfg_ready, 1'b0);
    drive(1'b0, 0, 0, 1'b0, nocfg, 1'b1);
    check_eq("t2_ready_free", bus.cfg_ready, 1'b1);
    pixel(100, 50);
    check_eq("t2_bg_addr", bus.mem_addr, 8050);
    idle(1);
    check_eq("t2_sp_rd", bus.mem_rd, 1'b1);
    check_eq("t2_sp_addr", bus.mem_addr, 77824);
    idle(2);
    check_eq("t2_idx", bus.idx_out, 4'd7);
    check_eq("t2_layer", bus.layer_sel, 1'b1);
    idle(1);

    // 3: transparent sprite pixel shows background
    rom[77824] = 4'd2;
    pixel(100, 50);
    idle(3);
    check_eq("t3_idx", bus.idx_out, 4'd9);
    check_eq("t3_layer", bus.layer_sel, 1'b0);
    idle(1);

    // 4: pending blocks a second request; cfg + frame_start same Clk
    send_cfg(mk(200, 100, 2, 1'b1), 1'b0);
    send_cfg(mk(600, 400, 5, 1'b1), 1'b0);
    check_eq("t4_not_accepted", bus.cfg_ready, 1'b0);
    drive(1'b0, 0, 0, 1'b0, nocfg, 1'b1);
    pixel(210, 110);
    idle(1);
    check_eq("t4_sp_addr_a", bus.mem_addr, 79178);
    idle(2);
    send_cfg(mk(300, 200, 3, 1'b1), 1'b1);
    check_eq("t4_ready_direct", bus.cfg_ready, 1'b1);
    pixel(305, 201);
    idle(1);
    check_eq("t4_sp_addr_c", bus.mem_addr, 79909);
    idle(3);

    // 5: wrap at the left edge hits, wrap the other way misses
    rom[77139] = 4'd5;
    rom[10104] = 4'd12;
    send_cfg(mk(1010, 50, 0, 1'b1), 1'b1);
    pixel(5, 60);
    idle(1);
    check_eq("t5_wrap_addr", bus.mem_addr, 77139);
    idle(2);
    check_eq("t5_wrap_idx", bus.idx_out, 4'd5);
    check_eq("t5_wrap_layer", bus.layer_sel, 1'b1);
    pixel(1009, 60);
    idle(1);
    check_eq("t5_nohit_rd", bus.mem_rd, 1'b0);
    idle(2);
    check_eq("t5_nohit_idx", bus.idx_out, 4'd12);
    check_eq("t5_nohit_layer", bus.layer_sel, 1'b0);
    idle(1);

    // 6: consecutive pix_en -> overrun sticky, then reset mid-pixel
    pixel(0, 0);
    pixel(1, 1);
    check_eq("t6_overrun", bus.overrun, 1'b1);
    idle(5);
    check_eq("t6_overrun_sticky", bus.overrun, 1'b1);
    async_reset();

    // random traffic
    for (int i = 0; i < 800; i++) begin
      r_pix = ($urandom_range(0, 99) < 55);
      if ($urandom_range(0, 1) == 1) begin
        r_x = (int'(m_active.x) + $urandom_range(0, 40) - 4) & 1023;
        r_y = (int'(m_active.y) + $urandom_range(0, 40) - 4) & 1023;
      end else begin
        r_x = $urandom_range(0, 639);
        r_y = $urandom_range(0, 479);
      end
      r_cv = ($urandom_range(0, 99) < 10);
      r_c  = mk($urandom_range(0, 1023), $urandom_range(0, 1023),
                $urandom_range(0, 7), ($urandom_range(0, 3) != 0));
      r_c.hflip = 1'($urandom_range(0, 1));
      r_fs = ($urandom_range(0, 99) < 6);
      drive(r_pix, r_x, r_y, r_cv, r_c, r_fs);
    end

    idle(6);
    check_eq("drain_out_q", out_q.size(), 0);
    check_eq("drain_rd_q", rd_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
